rst_seq_ctrl: RTL and testbench

- Parametrised power-on reset and strap sequencer. It sits between the board-level SYSRSTn/PLL strap pins and the core and peripheral reset domains inside asic_top.
- It synchronises the external reset and latches the PLL configuration and mode straps after a hold period. It then waits for PLL lock, with a timeout and bypass fallback, and releases N reset domains in a staggered order.
- It also supports software-requested warm reset and automatic re-sequencing on loss of PLL lock.

---
 rtl/rst_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Power-on reset and strap sequencer. Synchronises the board reset, waits a
// hold period, latches the PLL straps, waits for PLL lock (with a timeout that
// falls back to bypass), then releases N_RST active-low reset domains one at a
// time, STAGGER cycles apart. In RUN it supports a software warm reset and
// re-sequences the non-always-on domains if PLL lock is lost.
//
// Ports:
//   sys_clk      in   sole clock
//   rst_n        in   asynchronous active-low reset (deassertion synchronised)
//   pll_cfg_in   in   PLL configuration strap pins (static during hold)
//   pll_mode_in  in   bypass strap, 1 = PLL bypass
//   pll_lock     in   PLL lock indicator, asynchronous
//   sw_rst_req   in   warm-reset request level, honoured only in RUN
//   pll_cfg      out  latched PLL configuration
//   pll_bypass   out  latched bypass strap, or forced bypass after a timeout
//   rst_out_n    out  per-domain active-low resets, domain 0 is always-on
//   seq_done     out  high while in RUN
//   lock_timeout out  sticky, set when the lock wait expired
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int N_RST        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 1024,
  parameter int SW_HOLD      = 16,
  parameter int STAGGER      = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int CFG_W        = 6,
  parameter int CNT_W        = 17
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] pll_cfg_in,
  input  logic             pll_mode_in,
  input  logic             pll_lock,
  input  logic             sw_rst_req,
  output logic [CFG_W-1:0] pll_cfg,
  output logic             pll_bypass,
  output logic [N_RST-1:0] rst_out_n,
  output logic             seq_done,
  output logic             lock_timeout
);

  localparam logic [2:0] ST_HOLD    = 3'd0;
  localparam logic [2:0] ST_LOCK    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_WHOLD   = 3'd4;

  // Terminal counts: each phase counts up from 0 and leaves on its last value.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WHOLD_LAST = CNT_W'(SW_HOLD - 1);
  localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_prev;
  logic                   rst_sync;
  logic                   lock_sync;
  logic                   lock_up;
  logic                   lock_down;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;

  assign rst_sync  = rst_sync_q[SYNC_STAGES-1];
  assign lock_sync = lock_sync_q[SYNC_STAGES-1];
  // Lock is only trusted (or considered lost) after two agreeing cycles.
  assign lock_up   = lock_sync & lock_prev;
  assign lock_down = ~lock_sync & ~lock_prev;

  // Reset assertion clears the chain at once; deassertion walks through it.
  // NOTE: sequential state uses non-blocking assignments so every flop in a
  // chain samples its neighbour's pre-edge value.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
      lock_prev   <= 1'b0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
      lock_prev   <= lock_sync;
    end
  end

  // Sequencer. While the synchronised reset is still low every register
  // simply keeps the value rst_n forced, so no second reset branch is needed.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      pll_cfg      <= '0;
      pll_bypass   <= 1'b0;
      rst_out_n    <= '0;
      seq_done     <= 1'b0;
      lock_timeout <= 1'b0;
    end else if (rst_sync) begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            pll_cfg    <= pll_cfg_in;
            pll_bypass <= pll_mode_in;
            cnt        <= '0;
            state      <= ST_LOCK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_LOCK: begin
          if (pll_bypass || lock_up) begin
            cnt   <= '0;
            state <= ST_RELEASE;
          end else if (cnt == LOCK_LAST) begin
            // Give up on the PLL; bypass stays forced until the next rst_n.
            lock_timeout <= 1'b1;
            pll_bypass   <= 1'b1;
            cnt          <= '0;
            state        <= ST_RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          // Domains are released as a thermometer: shifting a 1 in from the
          // bottom keeps the order, and already-high bits (domain 0 after a
          // warm reset) are simply skipped.
          if (&rst_out_n) begin
            seq_done <= 1'b1;
            state    <= ST_RUN;
          end else if (cnt == '0) begin
            rst_out_n <= (rst_out_n << 1) | N_RST'(1);
            cnt       <= STAG_LAST;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_RUN: begin
          // Lock loss wins over a simultaneous software request.
          if (!pll_bypass && lock_down) begin
            rst_out_n <= N_RST'(1);
            seq_done  <= 1'b0;
            cnt       <= '0;
            state     <= ST_LOCK;
          end else if (sw_rst_req) begin
            rst_out_n <= N_RST'(1);
            seq_done  <= 1'b0;
            cnt       <= '0;
            state     <= ST_WHOLD;
          end
        end

        ST_WHOLD: begin
          // WHOLD occupies exactly SW_HOLD cycles; straps are left untouched.
          if (cnt == WHOLD_LAST) begin
            cnt   <= '0;
            state <= ST_RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Self-checking bench for rst_seq_ctrl in the small configuration N_RST=3,
// HOLD_CYCLES=8, STAGGER=4, SW_HOLD=4, LOCK_TIMEOUT=32, SYNC_STAGES=2.
// A timeline model (phase + entry cycle, outputs derived by arithmetic from
// the entry cycle) is compared against the DUT after every clock edge.
// Directed scenarios pin the model with literal expectations, followed by a
// randomised phase.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int N     = 3;
  localparam int SYNC  = 2;
  localparam int HOLD  = 8;
  localparam int SWH   = 4;
  localparam int STAG  = 4;
  localparam int LTO   = 32;
  localparam int CFG_W = 6;
  localparam int CNT_W = 17;

  logic             clk;
  logic             rst_n;
  logic [CFG_W-1:0] pll_cfg_in;
  logic             pll_mode_in;
  logic             pll_lock;
  logic             sw_rst_req;
  logic [CFG_W-1:0] pll_cfg;
  logic             pll_bypass;
  logic [N-1:0]     rst_out_n;
  logic             seq_done;
  logic             lock_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  rst_seq_ctrl #(
    .N_RST(N), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .SW_HOLD(SWH),
    .STAGGER(STAG), .LOCK_TIMEOUT(LTO), .CFG_W(CFG_W), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(clk), .rst_n(rst_n), .pll_cfg_in(pll_cfg_in),
    .pll_mode_in(pll_mode_in), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .pll_cfg(pll_cfg), .pll_bypass(pll_bypass), .rst_out_n(rst_out_n),
    .seq_done(seq_done), .lock_timeout(lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return 32'({pll_cfg, pll_bypass, lock_timeout, seq_done, rst_out_n});
  endfunction

  // ---------------------------------------------------------------------------
  // Timeline model
  // ---------------------------------------------------------------------------
  typedef enum {M_RESET, M_HOLD, M_LOCK, M_REL, M_RUN, M_WHOLD} mph_e;

  mph_e             m_ph = M_RESET;
  int               m_k;      // consecutive edges with rst_n sampled high
  int               m_t0;     // T0 edge
  int               m_tent;   // edge on which LOCK / WHOLD was entered
  int               m_e;      // first edge spent in RELEASE
  int               m_first;  // lowest domain this RELEASE has to raise
  bit [7:0]         m_hist;   // pll_lock samples, [0] = previous edge
  logic [CFG_W-1:0] m_cfg;
  logic             m_byp, m_to, m_done;
  logic [N-1:0]     m_rst;

  task automatic model_step();
    bit lk_now, lk_old;
    // The debounced view at edge t is built from the raw samples at
    // t-SYNC and t-SYNC-1.
    lk_now = m_hist[SYNC-1];
    lk_old = m_hist[SYNC];
    if (!rst_n) begin
      m_ph = M_RESET; m_k = 0; m_hist = '0;
      m_cfg = '0; m_byp = 1'b0; m_to = 1'b0; m_done = 1'b0; m_rst = '0;
    end else begin
      if (m_k <= SYNC) m_k++;
      if (m_ph == M_RESET && m_k == SYNC + 1) begin
        m_t0 = cyc;
        m_ph = M_HOLD;
      end
      case (m_ph)
        M_HOLD: if (cyc == m_t0 + HOLD - 1) begin
          m_cfg = pll_cfg_in; m_byp = pll_mode_in;
          m_ph = M_LOCK; m_tent = cyc; m_first = 0;
        end
        M_LOCK: begin
          if (m_byp || (lk_now && lk_old)) begin
            m_ph = M_REL; m_e = cyc + 1;
          end else if (cyc - m_tent == LTO) begin
            m_to = 1'b1; m_byp = 1'b1; m_ph = M_REL; m_e = cyc + 1;
          end
        end
        M_REL: begin
          for (int i = 0; i < N; i++)
            m_rst[i] = (i < m_first) || (cyc >= m_e + (i - m_first) * STAG);
          if (cyc == m_e + (N - 1 - m_first) * STAG + 1) begin
            m_done = 1'b1; m_ph = M_RUN;
          end
        end
        M_RUN: begin
          if (!m_byp && !lk_now && !lk_old) begin
            m_ph = M_LOCK; m_tent = cyc; m_rst = N'(1); m_done = 1'b0; m_first = 1;
          end else if (sw_rst_req) begin
            m_ph = M_WHOLD; m_tent = cyc; m_rst = N'(1); m_done = 1'b0; m_first = 1;
          end
        end
        M_WHOLD: if (cyc - m_tent == SWH) begin
          m_ph = M_REL; m_e = cyc + 1;
        end
        default: ;
      endcase
      m_hist = {m_hist[6:0], pll_lock};
    end
  endtask

  // Single compare process: advance the model on each edge, compare shortly after.
  always @(posedge clk) begin
    logic [31:0] thermo;
    cyc++;
    model_step();
    #2;
    check("outputs{cfg,byp,to,done,rst}", pack_out(),
          32'({m_cfg, m_byp, m_to, m_done, m_rst}));
    thermo = (32'd1 << $countones(rst_out_n)) - 32'd1;
    check("rst_order", 32'(rst_out_n), thermo);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Land 2 time units after edge number t.
  task automatic at(input int t);
    repeat (t - cyc) @(posedge clk);
    #2;
  endtask

  // Reset, apply straps, release rst_n; returns the T0 edge number.
  task automatic cold_boot(input logic [CFG_W-1:0] cfg, input logic mode,
                           input logic sw, output int t0);
    @(negedge clk);
    rst_n = 1'b0; pll_cfg_in = cfg; pll_mode_in = mode;
    pll_lock = 1'b0; sw_rst_req = sw;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc + 1 + SYNC;
  endtask

  initial begin
    int t0, w, l, r, d, r2;
    rst_n = 1'b0; pll_cfg_in = 6'h2A; pll_mode_in = 1'b1;
    pll_lock = 1'b0; sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", pack_out(), 32'd0);

    // Cold boot in bypass.
    rst_n = 1'b1;
    t0 = cyc + 1 + SYNC;
    at(t0 + 6);  check("cfg_before_latch", 32'(pll_cfg), 32'h00);
    at(t0 + 7);  check("cfg_latched", 32'(pll_cfg), 32'h2A);
                 check("bypass_latched", 32'(pll_bypass), 32'd1);
    at(t0 + 8);  check("rst_T0+8", 32'(rst_out_n), 32'b000);
    at(t0 + 9);  check("rst_T0+9", 32'(rst_out_n), 32'b001);
    at(t0 + 12); check("rst_T0+12", 32'(rst_out_n), 32'b001);
    at(t0 + 13); check("rst_T0+13", 32'(rst_out_n), 32'b011);
    at(t0 + 17); check("rst_T0+17", 32'(rst_out_n), 32'b111);
                 check("done_T0+17", 32'(seq_done), 32'd0);
    at(t0 + 18); check("done_T0+18", 32'(seq_done), 32'd1);

    // Warm reset; the strap pins change but must not be re-latched.
    at(t0 + 20);
    @(negedge clk); pll_cfg_in = 6'h15; sw_rst_req = 1'b1;
    w = t0 + 21;
    at(w);       check("warm_rst", 32'(rst_out_n), 32'b001);
                 check("warm_done", 32'(seq_done), 32'd0);
    @(negedge clk); sw_rst_req = 1'b0;
    at(w + 4);   check("warm_W+4", 32'(rst_out_n), 32'b001);
    at(w + 5);   check("warm_W+5", 32'(rst_out_n), 32'b011);
    at(w + 9);   check("warm_W+9", 32'(rst_out_n), 32'b111);
    at(w + 10);  check("warm_done_again", 32'(seq_done), 32'd1);
                 check("warm_cfg_kept", 32'(pll_cfg), 32'h2A);

    // Lock path, then lock loss coinciding with a software request.
    cold_boot(6'h13, 1'b0, 1'b0, t0);
    l = t0 + 7;
    at(l + 9);
    @(negedge clk); pll_lock = 1'b1;
    r = l + 10;
    at(r + 3);   check("lock_R+3", 32'(rst_out_n), 32'b000);
    at(r + 4);   check("lock_R+4", 32'(rst_out_n), 32'b001);
                 check("lock_no_timeout", 32'(lock_timeout), 32'd0);
    at(r + 19);
    @(negedge clk); pll_lock = 1'b0;
    d = r + 20;
    at(d + 2);
    @(negedge clk); sw_rst_req = 1'b1;
    at(d + 3);   check("loss_rst", 32'(rst_out_n), 32'b001);
                 check("loss_done", 32'(seq_done), 32'd0);
    @(negedge clk); sw_rst_req = 1'b0;
    at(d + 11);  check("loss_waits_lock", 32'(rst_out_n), 32'b001);
    @(negedge clk); pll_lock = 1'b1;
    r2 = d + 12;
    at(r2 + 4);  check("relock_bit1", 32'(rst_out_n), 32'b011);
    at(r2 + 7);  check("relock_gap", 32'(rst_out_n), 32'b011);
    at(r2 + 8);  check("relock_bit2", 32'(rst_out_n), 32'b111);
    at(r2 + 9);  check("relock_done", 32'(seq_done), 32'd1);

    // Lock timeout; sticky flags survive a warm reset.
    cold_boot(6'h07, 1'b0, 1'b0, t0);
    l = t0 + 7;
    at(l + 31);  check("timeout_not_yet", 32'(lock_timeout), 32'd0);
    at(l + 32);  check("timeout_set", 32'(lock_timeout), 32'd1);
                 check("timeout_bypass", 32'(pll_bypass), 32'd1);
    at(l + 44);
    @(negedge clk); sw_rst_req = 1'b1;
    w = l + 45;
    at(w);
    @(negedge clk); sw_rst_req = 1'b0;
    at(w + 10);  check("timeout_warm_done", 32'(seq_done), 32'd1);
                 check("timeout_sticky", 32'(lock_timeout), 32'd1);
                 check("bypass_sticky", 32'(pll_bypass), 32'd1);

    // Reset in the middle of RELEASE, then a restart with sw_rst_req held high.
    cold_boot(6'h2A, 1'b1, 1'b0, t0);
    at(t0 + 14); check("mid_release", 32'(rst_out_n), 32'b011);
    @(negedge clk); rst_n = 1'b0;
    #1;          check("async_reset", pack_out(), 32'd0);
    cold_boot(6'h31, 1'b1, 1'b1, t0);
    at(t0 + 17); check("restart_rst", 32'(rst_out_n), 32'b111);
    at(t0 + 18); check("restart_done", 32'(seq_done), 32'd1);
    at(t0 + 19); check("held_sw_retrigger", 32'(rst_out_n), 32'b001);
    @(negedge clk); sw_rst_req = 1'b0;

    // Randomised phase: the compare process checks every cycle.
    for (int it = 0; it < 40; it++) begin
      int len, p_lock;
      cold_boot(CFG_W'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), t0);
      len    = $urandom_range(80, 250);
      p_lock = $urandom_range(4, 40);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if ($urandom_range(0, p_lock) == 0) pll_lock = ~pll_lock;
        sw_rst_req = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 15) == 0) pll_cfg_in = CFG_W'($urandom);
        rst_n = ($urandom_range(0, 399) != 0);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
